// File: rtl/audio_playback_ctrl_pkg.sv
// Shared state encoding and helpers for the audio playback sequencer.
// Combinational definitions only; no latency or backpressure.
package audio_playback_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_ROM = 3'd2,
    ST_LOAD     = 3'd3,
    ST_HOLD     = 3'd4
  } state_t;

  // Mid-scale duty code: the PWM output averages to silence.
  function automatic int unsigned silence_code(input int unsigned data_w);
    return 32'd1 << (data_w - 1);
  endfunction

endpackage

// File: rtl/audio_playback_ctrl_if.sv
// Command, sample-ROM and PWM-duty signals of the playback sequencer.
// Wiring only; the sequencer never stalls its command or ROM side.
interface audio_playback_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);

  logic              cmd_play;
  logic              cmd_stop;
  logic              loop_en;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] duty;
  logic              duty_load;
  logic              busy;
  logic              done;

  modport master (
    output cmd_play, cmd_stop, loop_en, start_addr, end_addr, rom_data,
    input  rom_addr, duty, duty_load, busy, done
  );

  modport slave (
    input  cmd_play, cmd_stop, loop_en, start_addr, end_addr, rom_data,
    output rom_addr, duty, duty_load, busy, done
  );

endinterface

// File: rtl/audio_playback_ctrl_sample_tick_gen.sv
// Sample-period tick counter: clear-able, terminal count at CLK_DIV-4.
// tc is combinational from the count register; no backpressure.
module audio_playback_ctrl_sample_tick_gen #(
  parameter int CLK_DIV = 12500
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = $clog2(CLK_DIV);
  // FETCH, WAIT_ROM and LOAD consume three cycles of every sample period.
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 4);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == TERM);

endmodule

// File: rtl/audio_playback_ctrl.sv
// Plays ROM samples [start..end] as PWM duty values, one every CLK_DIV cycles.
// cmd_play to first duty_load is 3 cycles; commands are never stalled (ignored when not applicable).
module audio_playback_ctrl
  import audio_playback_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 12500,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8
) (
  input logic                  clk,
  input logic                  reset,
  audio_playback_ctrl_if.slave bus
);

  localparam logic [DATA_W-1:0] SILENCE = DATA_W'(silence_code(DATA_W));

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_nxt;
  logic [ADDR_W-1:0] start_q, start_nxt;
  logic [ADDR_W-1:0] end_q, end_nxt;
  logic              loop_q, loop_nxt;
  logic [DATA_W-1:0] duty_q, duty_nxt;
  logic              duty_load_q, duty_load_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;
  logic              tick_clr, tick_en, tick_tc;

  audio_playback_ctrl_sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (tick_clr),
    .en    (tick_en),
    .tc    (tick_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rom_addr_q  <= '0;
      start_q     <= '0;
      end_q       <= '0;
      loop_q      <= 1'b0;
      duty_q      <= SILENCE;
      duty_load_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      rom_addr_q  <= rom_addr_nxt;
      start_q     <= start_nxt;
      end_q       <= end_nxt;
      loop_q      <= loop_nxt;
      duty_q      <= duty_nxt;
      duty_load_q <= duty_load_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    rom_addr_nxt  = rom_addr_q;
    start_nxt     = start_q;
    end_nxt       = end_q;
    loop_nxt      = loop_q;
    duty_nxt      = duty_q;
    duty_load_nxt = 1'b0;
    busy_nxt      = busy_q;
    done_nxt      = 1'b0;
    tick_clr      = 1'b0;
    tick_en       = 1'b0;

    // Stop has priority over everything, including a simultaneous play.
    if (state != ST_IDLE && bus.cmd_stop) begin
      state_nxt     = ST_IDLE;
      duty_nxt      = SILENCE;
      duty_load_nxt = 1'b1;
      done_nxt      = 1'b1;
      busy_nxt      = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_play && !bus.cmd_stop) begin
            if (bus.start_addr > bus.end_addr) begin
              done_nxt = 1'b1;
            end else begin
              start_nxt    = bus.start_addr;
              end_nxt      = bus.end_addr;
              loop_nxt     = bus.loop_en;
              rom_addr_nxt = bus.start_addr;
              busy_nxt     = 1'b1;
              state_nxt    = ST_FETCH;
            end
          end
        end
        ST_FETCH: state_nxt = ST_WAIT_ROM;
        ST_WAIT_ROM: begin
          duty_nxt      = bus.rom_data;
          duty_load_nxt = 1'b1;
          state_nxt     = ST_LOAD;
        end
        ST_LOAD: begin
          tick_clr  = 1'b1;
          state_nxt = ST_HOLD;
        end
        ST_HOLD: begin
          tick_en = 1'b1;
          if (tick_tc) begin
            if (rom_addr_q != end_q) begin
              rom_addr_nxt = rom_addr_q + ADDR_W'(1);
              state_nxt    = ST_FETCH;
            end else if (loop_q) begin
              rom_addr_nxt = start_q;
              state_nxt    = ST_FETCH;
            end else begin
              duty_nxt      = SILENCE;
              duty_load_nxt = 1'b1;
              done_nxt      = 1'b1;
              busy_nxt      = 1'b0;
              state_nxt     = ST_IDLE;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.duty      = duty_q;
  assign bus.duty_load = duty_load_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_audio_playback_ctrl.sv
// Directed and randomized playback runs checked cycle by cycle against a timeline model.
module tb_audio_playback_ctrl;

  localparam int          C   = 8;
  localparam logic [7:0]  SIL = 8'h80;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic [15:0] cur_addr;

  audio_playback_ctrl_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  audio_playback_ctrl #(.CLK_DIV(C), .ADDR_W(16), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [15:0] a);
    return a[7:0] + 8'h10;
  endfunction

  // Synchronous ROM: data follows the address by one clock.
  always @(posedge clk) bus.rom_data <= rom_f(bus.rom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] d, input logic ld,
                         input logic dn, input logic bz, input logic [15:0] a);
    chk({tag, " duty"}, 32'(bus.duty), 32'(d));
    chk({tag, " duty_load"}, 32'(bus.duty_load), 32'(ld));
    chk({tag, " done"}, 32'(bus.done), 32'(dn));
    chk({tag, " busy"}, 32'(bus.busy), 32'(bz));
    chk({tag, " rom_addr"}, 32'(bus.rom_addr), 32'(a));
  endtask

  // Idle cycles: nothing may move except an optional done pulse in the first cycle.
  task automatic idle_run(input string tag, input int n, input bit first_done);
    for (int c = 1; c <= n; c++) begin
      chk_all($sformatf("%s c%0d", tag, c), SIL, 1'b0, first_done && c == 1, 1'b0, cur_addr);
      tick();
    end
  endtask

  // Sample k is strobed at cycle 3+k*C after play; one-shot ends with a silence strobe at len*C+1.
  task automatic play_run(input string tag, input int s, input int e, input bit lp,
                          input int stop_at, input int busy_play_at, input int n_cyc);
    int          len;
    int          k;
    int          stop_c;
    bit          stopped;
    bit          fin;
    logic [7:0]  ed;
    logic [15:0] ea;
    logic        exp_load, exp_done, exp_busy;
    len     = e - s + 1;
    stopped = 1'b0;
    stop_c  = 0;
    ed      = SIL;
    ea      = 16'(s);
    bus.start_addr = 16'(s);
    bus.end_addr   = 16'(e);
    bus.loop_en    = lp;
    bus.cmd_play   = 1'b1;
    tick();
    bus.cmd_play   = 1'b0;
    bus.start_addr = 16'($urandom);
    bus.end_addr   = 16'($urandom);
    bus.loop_en    = 1'($urandom);
    for (int c = 1; c <= n_cyc; c++) begin
      exp_load = 1'b0;
      exp_done = 1'b0;
      exp_busy = 1'b0;
      fin = !lp && (c > len * C);
      if (stopped) begin
        if (c == stop_c + 1) begin
          exp_load = 1'b1;
          exp_done = 1'b1;
          ed       = SIL;
        end
      end else if (fin) begin
        if (c == len * C + 1) begin
          exp_load = 1'b1;
          exp_done = 1'b1;
          ed       = SIL;
        end
      end else begin
        exp_busy = 1'b1;
        k  = (c - 1) / C;
        ea = 16'(s + k % len);
        if (c >= 3 && (c - 3) % C == 0) begin
          exp_load = 1'b1;
          ed       = rom_f(16'(s + ((c - 3) / C) % len));
        end
      end
      chk_all($sformatf("%s c%0d", tag, c), ed, exp_load, exp_done, exp_busy, ea);
      if (c == stop_at) begin
        bus.cmd_stop = 1'b1;
        if (exp_busy) begin
          stopped = 1'b1;
          stop_c  = c;
        end
      end
      if (c == busy_play_at && exp_busy && !stopped) begin
        bus.cmd_play   = 1'b1;
        bus.start_addr = 16'($urandom_range(0, 100));
        bus.end_addr   = 16'($urandom_range(101, 200));
        bus.loop_en    = 1'($urandom);
      end
      tick();
      bus.cmd_stop = 1'b0;
      bus.cmd_play = 1'b0;
    end
    cur_addr = ea;
  endtask

  initial begin
    int s, len, stop_at, n_cyc, bp;
    bit lp;
    n_cmp = 0;
    n_err = 0;
    cur_addr = '0;
    reset = 1'b0;
    bus.cmd_play   = 1'b0;
    bus.cmd_stop   = 1'b0;
    bus.loop_en    = 1'b0;
    bus.start_addr = '0;
    bus.end_addr   = '0;
    tick();
    tick();
    chk_all("reset", SIL, 1'b0, 1'b0, 1'b0, 16'h0000);
    reset = 1'b1;
    idle_run("post_reset", 3, 1'b0);

    play_run("oneshot_5_7", 5, 7, 1'b0, 0, 0, 3 * C + 5);
    play_run("loop_2_3_stop", 2, 3, 1'b1, 20, 13, 26);

    bus.start_addr = 16'd9;
    bus.end_addr   = 16'd4;
    bus.cmd_play   = 1'b1;
    tick();
    bus.cmd_play   = 1'b0;
    idle_run("reject_9_4", 6, 1'b1);

    bus.start_addr = 16'd5;
    bus.end_addr   = 16'd7;
    bus.cmd_play   = 1'b1;
    bus.cmd_stop   = 1'b1;
    tick();
    bus.cmd_play   = 1'b0;
    bus.cmd_stop   = 1'b0;
    idle_run("play_stop_idle", 6, 1'b0);
    bus.cmd_stop = 1'b1;
    tick();
    bus.cmd_stop = 1'b0;
    idle_run("stop_idle", 3, 1'b0);

    play_run("single_oneshot", 16'h30, 16'h30, 1'b0, 0, 5, C + 4);
    play_run("single_loop", 16'h41, 16'h41, 1'b1, 3 * C + 2, 0, 3 * C + 5);
    play_run("top_wrap_loop", 16'hFFFE, 16'hFFFF, 1'b1, 4 * C + 1, 0, 4 * C + 4);

    for (int i = 0; i < 8; i++) begin
      s   = $urandom_range(0, 16'hFFF0);
      len = $urandom_range(1, 3);
      lp  = 1'($urandom);
      bp  = $urandom_range(1, 2 * C);
      if (lp) begin
        stop_at = $urandom_range(4, 3 * C + 2);
        n_cyc   = stop_at + 3;
      end else begin
        stop_at = ($urandom_range(0, 1) == 1) ? $urandom_range(2, len * C + 2) : 0;
        n_cyc   = len * C + 4;
      end
      play_run($sformatf("rand%0d", i), s, s + len - 1, lp, stop_at, bp, n_cyc);
    end

    // Asynchronous reset while the second sample sits in WAIT_ROM.
    bus.start_addr = 16'h20;
    bus.end_addr   = 16'h21;
    bus.loop_en    = 1'b0;
    bus.cmd_play   = 1'b1;
    tick();
    bus.cmd_play   = 1'b0;
    for (int c = 1; c < C + 2; c++) tick();
    chk_all("pre_async_reset", rom_f(16'h20), 1'b0, 1'b0, 1'b1, 16'h21);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_reset", SIL, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    chk_all("reset_hold", SIL, 1'b0, 1'b0, 1'b0, 16'h0000);
    #2;
    reset = 1'b1;
    cur_addr = '0;
    tick();
    idle_run("after_async_reset", 4, 1'b0);
    play_run("restart", 7, 8, 1'b0, 0, 0, 2 * C + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
